dmem_rr_arbiter: RTL and testbench

Round-robin arbiter sharing one data-memory channel among `NUM_CONSUMERS` LSU-style requesters, each with separate read and write request buses. It sits between a group of LSUs and one channel of the data memory cache/controller, and uses the same level valid/ready handshake on both sides. It holds at most one outstanding transaction. Fairness is by rotating pointer, so a requester that holds its request is served within `NUM_CONSUMERS` grants.

---
 rtl/gpu_pkg.sv | 16 +
 rtl/rr_picker.sv | 31 +++
 rtl/dmem_rr_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dmem_rr_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package gpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    RELAY
  } arb_state_t;

  // Width of a consumer index; a single consumer still gets one bit.
  function automatic int unsigned id_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester after last_id, wrapping.
module rr_picker #(
  parameter int unsigned N       = 4,
  parameter int unsigned ID_BITS = 2
) (
  input  logic [N-1:0]       req_mask,
  input  logic [ID_BITS-1:0] last_id,
  output logic               found,
  output logic [ID_BITS-1:0] pick_id
);

  int unsigned        w_idx;
  logic [ID_BITS-1:0] w_idx_cut;

  // Walk offsets 1..N from last_id so the previous winner is checked last.
  always_comb begin
    found     = 1'b0;
    pick_id   = '0;
    w_idx     = 0;
    w_idx_cut = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      w_idx     = (32'(last_id) + i) % N;
      w_idx_cut = ID_BITS'(w_idx);
      if (!found && req_mask[w_idx_cut]) begin
        found   = 1'b1;
        pick_id = w_idx_cut;
      end
    end
  end

endmodule

// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter sharing one data-memory channel among several LSU requesters.
// One transaction in flight; write wins over read when a consumer asserts both.
module dmem_rr_arbiter
  import gpu_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned NUM_CONSUMERS = 4,
  parameter int unsigned ID_BITS       = id_bits(NUM_CONSUMERS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
  input  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
  output logic [DATA_BITS-1:0]     consumer_read_data    [NUM_CONSUMERS],
  input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
  input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS],
  input  logic [DATA_BITS-1:0]     consumer_write_data    [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_write_ready,
  output logic                     mem_read_valid,
  output logic [ADDR_BITS-1:0]     mem_read_address,
  input  logic                     mem_read_ready,
  input  logic [DATA_BITS-1:0]     mem_read_data,
  output logic                     mem_write_valid,
  output logic [ADDR_BITS-1:0]     mem_write_address,
  output logic [DATA_BITS-1:0]     mem_write_data,
  input  logic                     mem_write_ready,
  output logic                     busy,
  output logic [ID_BITS-1:0]       grant_id
);

  // Start as if the last consumer was served so consumer 0 wins first.
  localparam logic [ID_BITS-1:0] LastIdReset = ID_BITS'(NUM_CONSUMERS - 1);

  arb_state_t               r_state, w_state_next;
  logic [ID_BITS-1:0]       r_last_id, w_last_id_next;
  logic [ID_BITS-1:0]       r_grant_id, w_grant_id_next;
  logic                     r_is_write, w_is_write_next;
  logic [ADDR_BITS-1:0]     r_addr, w_addr_next;
  logic [DATA_BITS-1:0]     r_wdata, w_wdata_next;
  logic [DATA_BITS-1:0]     r_read_data [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     w_read_data_next [NUM_CONSUMERS];
  logic [NUM_CONSUMERS-1:0] r_rd_ready, w_rd_ready_next;
  logic [NUM_CONSUMERS-1:0] r_wr_ready, w_wr_ready_next;
  logic                     r_mem_rd_valid, w_mem_rd_valid_next;
  logic                     r_mem_wr_valid, w_mem_wr_valid_next;

  logic                     w_found;
  logic [ID_BITS-1:0]       w_pick_id;
  logic [NUM_CONSUMERS-1:0] w_req_mask;

  assign w_req_mask = consumer_read_valid | consumer_write_valid;

  rr_picker #(
    .N       (NUM_CONSUMERS),
    .ID_BITS (ID_BITS)
  ) u_picker (
    .req_mask (w_req_mask),
    .last_id  (r_last_id),
    .found    (w_found),
    .pick_id  (w_pick_id)
  );

  // Next-state and next-output logic; every target holds by default.
  always_comb begin
    w_state_next        = r_state;
    w_last_id_next      = r_last_id;
    w_grant_id_next     = r_grant_id;
    w_is_write_next     = r_is_write;
    w_addr_next         = r_addr;
    w_wdata_next        = r_wdata;
    w_read_data_next    = r_read_data;
    w_rd_ready_next     = r_rd_ready;
    w_wr_ready_next     = r_wr_ready;
    w_mem_rd_valid_next = r_mem_rd_valid;
    w_mem_wr_valid_next = r_mem_wr_valid;

    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_grant_id_next = w_pick_id;
          if (consumer_write_valid[w_pick_id]) begin
            w_is_write_next     = 1'b1;
            w_addr_next         = consumer_write_address[w_pick_id];
            w_wdata_next        = consumer_write_data[w_pick_id];
            w_mem_wr_valid_next = 1'b1;
            w_state_next        = WRITE_WAIT;
          end else begin
            w_is_write_next     = 1'b0;
            w_addr_next         = consumer_read_address[w_pick_id];
            w_mem_rd_valid_next = 1'b1;
            w_state_next        = READ_WAIT;
          end
        end
      end
      READ_WAIT: begin
        if (mem_read_ready) begin
          w_mem_rd_valid_next          = 1'b0;
          w_read_data_next[r_grant_id] = mem_read_data;
          w_rd_ready_next[r_grant_id]  = 1'b1;
          w_state_next                 = RELAY;
        end
      end
      WRITE_WAIT: begin
        if (mem_write_ready) begin
          w_mem_wr_valid_next         = 1'b0;
          w_wr_ready_next[r_grant_id] = 1'b1;
          w_state_next                = RELAY;
        end
      end
      RELAY: begin
        // Release only once the served request line has been withdrawn.
        if (r_is_write ? !consumer_write_valid[r_grant_id]
                       : !consumer_read_valid[r_grant_id]) begin
          w_rd_ready_next = '0;
          w_wr_ready_next = '0;
          w_last_id_next  = r_grant_id;
          w_state_next    = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State and output registers; reset abandons any outstanding request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_last_id      <= LastIdReset;
      r_grant_id     <= '0;
      r_is_write     <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) r_read_data[i] <= '0;
      r_rd_ready     <= '0;
      r_wr_ready     <= '0;
      r_mem_rd_valid <= 1'b0;
      r_mem_wr_valid <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_last_id      <= w_last_id_next;
      r_grant_id     <= w_grant_id_next;
      r_is_write     <= w_is_write_next;
      r_addr         <= w_addr_next;
      r_wdata        <= w_wdata_next;
      r_read_data    <= w_read_data_next;
      r_rd_ready     <= w_rd_ready_next;
      r_wr_ready     <= w_wr_ready_next;
      r_mem_rd_valid <= w_mem_rd_valid_next;
      r_mem_wr_valid <= w_mem_wr_valid_next;
    end
  end

  assign consumer_read_ready  = r_rd_ready;
  assign consumer_write_ready = r_wr_ready;
  assign consumer_read_data   = r_read_data;
  assign mem_read_valid       = r_mem_rd_valid;
  assign mem_write_valid      = r_mem_wr_valid;
  assign mem_read_address     = r_addr;
  assign mem_write_address    = r_addr;
  assign mem_write_data       = r_wdata;
  assign busy                 = (r_state != IDLE);
  assign grant_id             = r_grant_id;

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Directed self-checking bench for dmem_rr_arbiter (default 4 consumers, 8-bit).
module tb_dmem_rr_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] rd_valid;
  logic [7:0] rd_addr [4];
  logic [3:0] rd_ready;
  logic [7:0] rd_data [4];
  logic [3:0] wr_valid;
  logic [7:0] wr_addr [4];
  logic [7:0] wr_data [4];
  logic [3:0] wr_ready;
  logic       mem_read_valid;
  logic [7:0] mem_read_address;
  logic       mem_read_ready;
  logic [7:0] mem_read_data;
  logic       mem_write_valid;
  logic [7:0] mem_write_address;
  logic [7:0] mem_write_data;
  logic       mem_write_ready;
  logic       busy;
  logic [1:0] grant_id;

  int tests_run = 0;
  int tests_failed = 0;
  logic mon_en = 1'b0;

  dmem_rr_arbiter dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (rd_valid),
    .consumer_read_address  (rd_addr),
    .consumer_read_ready    (rd_ready),
    .consumer_read_data     (rd_data),
    .consumer_write_valid   (wr_valid),
    .consumer_write_address (wr_addr),
    .consumer_write_data    (wr_data),
    .consumer_write_ready   (wr_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready),
    .busy                   (busy),
    .grant_id               (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Wait (bounded) for a read request, then check who and where.
  task automatic wait_read(input string tag, input logic [1:0] id, input logic [7:0] addr);
    for (int k = 0; k < 10; k++) begin
      if (mem_read_valid) break;
      tick();
    end
    check({tag, "_rvalid"}, mem_read_valid, 1);
    check({tag, "_id"}, grant_id, id);
    check({tag, "_raddr"}, mem_read_address, addr);
  endtask

  task automatic wait_write(input string tag, input logic [1:0] id, input logic [7:0] addr,
                            input logic [7:0] data);
    for (int k = 0; k < 10; k++) begin
      if (mem_write_valid) break;
      tick();
    end
    check({tag, "_wvalid"}, mem_write_valid, 1);
    check({tag, "_id"}, grant_id, id);
    check({tag, "_waddr"}, mem_write_address, addr);
    check({tag, "_wdata"}, mem_write_data, data);
  endtask

  // Zero-wait memory reply for the current read; consumer ready follows next edge.
  task automatic serve_read(input string tag, input logic [1:0] id, input logic [7:0] data);
    mem_read_data  = data;
    mem_read_ready = 1'b1;
    tick();
    mem_read_ready = 1'b0;
    check({tag, "_rdy"}, rd_ready[id], 1);
    check({tag, "_data"}, rd_data[id], data);
    check({tag, "_rvalid_low"}, mem_read_valid, 0);
  endtask

  // Continuous protocol invariants once out of initial reset.
  always @(negedge clk) begin
    if (mon_en) begin
      check("no_rw_overlap", mem_read_valid & mem_write_valid, 0);
      check("ready_onehot", ($countones(rd_ready | wr_ready) <= 1), 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [1:0] rr_order [5];

  initial begin
    reset = 1'b0;
    rd_valid = '0;
    wr_valid = '0;
    mem_read_ready = 1'b0;
    mem_write_ready = 1'b0;
    mem_read_data = '0;
    for (int i = 0; i < 4; i++) begin
      rd_addr[i] = '0;
      wr_addr[i] = '0;
      wr_data[i] = '0;
    end
    repeat (2) tick();

    // Reset values
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    check("rst_mrv", mem_read_valid, 0);
    check("rst_mwv", mem_write_valid, 0);
    check("rst_rrdy", rd_ready, 0);
    check("rst_wrdy", wr_ready, 0);
    check("rst_maddr", mem_read_address, 0);
    check("rst_mwdata", mem_write_data, 0);
    for (int i = 0; i < 4; i++) check("rst_rdata", rd_data[i], 0);

    // Reset in the middle of READ_WAIT
    reset = 1'b1;
    mon_en = 1'b1;
    rd_addr[2] = 8'h33;
    rd_valid[2] = 1'b1;
    wait_read("pre_rst", 2'd2, 8'h33);
    rd_addr[0] = 8'h05;
    rd_valid[0] = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("midrst_mrv", mem_read_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_grant", grant_id, 0);
    check("midrst_maddr", mem_read_address, 0);
    tick();
    reset = 1'b1;
    wait_read("post_rst", 2'd0, 8'h05);
    serve_read("post_rst", 2'd0, 8'h77);
    rd_valid[0] = 1'b0;
    tick();
    check("post_rst_rdy_low", rd_ready[0], 0);
    check("post_rst_idle", busy, 0);
    wait_read("post_rst2", 2'd2, 8'h33);
    serve_read("post_rst2", 2'd2, 8'h12);
    rd_valid[2] = 1'b0;
    tick();

    // Single read with two wait cycles
    rd_addr[1] = 8'h2A;
    rd_valid[1] = 1'b1;
    wait_read("single", 2'd1, 8'h2A);
    tick();
    tick();
    check("single_hold_valid", mem_read_valid, 1);
    check("single_no_rdy", rd_ready[1], 0);
    serve_read("single", 2'd1, 8'h5C);
    tick();
    check("single_rdy_held", rd_ready[1], 1);
    rd_valid[1] = 1'b0;
    tick();
    check("single_rdy_low", rd_ready[1], 0);
    check("single_data_kept", rd_data[1], 8'h5C);
    check("single_idle", busy, 0);

    // Write takes priority over a simultaneous read from the same consumer
    wr_addr[3] = 8'h10;
    wr_data[3] = 8'hAB;
    rd_addr[3] = 8'h11;
    wr_valid[3] = 1'b1;
    rd_valid[3] = 1'b1;
    wait_write("wprio", 2'd3, 8'h10, 8'hAB);
    check("wprio_no_rd", mem_read_valid, 0);
    mem_write_ready = 1'b1;
    tick();
    mem_write_ready = 1'b0;
    check("wprio_wrdy", wr_ready[3], 1);
    check("wprio_no_rrdy", rd_ready[3], 0);
    check("wprio_wvalid_low", mem_write_valid, 0);
    wr_valid[3] = 1'b0;
    tick();
    check("wprio_wrdy_low", wr_ready[3], 0);
    wait_read("wprio_rd", 2'd3, 8'h11);
    serve_read("wprio_rd", 2'd3, 8'h3C);
    rd_valid[3] = 1'b0;
    tick();

    // Round robin with everyone requesting continuously
    rr_order[0] = 2'd0;
    rr_order[1] = 2'd1;
    rr_order[2] = 2'd2;
    rr_order[3] = 2'd3;
    rr_order[4] = 2'd0;
    for (int i = 0; i < 4; i++) rd_addr[i] = 8'h80 + 8'(i);
    rd_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_read("rr", rr_order[k], 8'h80 + 8'(rr_order[k]));
      serve_read("rr", rr_order[k], 8'hC0 + 8'(k));
      rd_valid[rr_order[k]] = 1'b0;
      tick();
      rd_valid[rr_order[k]] = 1'b1;
    end
    rd_valid = '0;
    tick();

    // Latched address; wrong-port ready ignored
    rd_addr[2] = 8'h40;
    rd_valid[2] = 1'b1;
    wait_read("latch", 2'd2, 8'h40);
    rd_addr[2] = 8'h41;
    mem_write_ready = 1'b1;
    tick();
    mem_write_ready = 1'b0;
    check("latch_addr", mem_read_address, 8'h40);
    check("latch_still_valid", mem_read_valid, 1);
    check("latch_no_wrdy", wr_ready[2], 0);
    check("latch_no_rrdy", rd_ready[2], 0);
    tick();
    check("latch_addr2", mem_read_address, 8'h40);
    serve_read("latch", 2'd2, 8'h99);
    rd_valid[2] = 1'b0;
    tick();

    // Early withdrawal is never serviced
    rd_addr[0] = 8'h50;
    rd_valid[0] = 1'b1;
    wait_read("early", 2'd0, 8'h50);
    rd_addr[1] = 8'h60;
    rd_valid[1] = 1'b1;
    tick();
    rd_valid[1] = 1'b0;
    serve_read("early", 2'd0, 8'hAA);
    rd_valid[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("early_idle", busy, 0);
      check("early_no_mrv", mem_read_valid, 0);
      check("early_no_rdy1", rd_ready[1], 0);
    end

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
